// File: rtl/projection_mem_ctrl.sv
// Sequencer for the dual-port projection memory: loads word pairs, then replays them to the encoder.
// Optional stall counter enabled by defining PROJ_CTRL_PERF_EN.
module projection_mem_ctrl #(
  parameter int Dhv_SIZE   = 4000,
  parameter int IN_WIDTH   = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             load_valid_i,
  output logic                             load_ready_o,
  input  logic [1:0][IN_WIDTH-1:0]         load_data_i,
  input  logic                             start_i,
  input  logic                             reload_i,
  output logic                             loaded_o,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [1:0][IN_WIDTH-1:0]         out_data_o,
  output logic                             out_last_o,
  output logic                             done_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr0_o,
  output logic [ADDR_WIDTH-1:0]            mem_addr1_o,
  output logic                             mem_we_o,
  output logic                             mem_re_o,
  output logic [1:0][IN_WIDTH-1:0]         mem_wdata_o,
  input  logic [1:0][IN_WIDTH-1:0]         mem_rdata_i,
  output logic [15:0]                      stall_count_o
);

  localparam int NUM_WORDS = Dhv_SIZE / IN_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TWO  = ADDR_WIDTH'(2);

  if (((NUM_WORDS % 2) != 0) || (NUM_WORDS > (1 << ADDR_WIDTH)) || (NUM_WORDS < 2)) begin : g_bad_cfg
    $error("projection_mem_ctrl: NUM_WORDS must be even, >= 2 and fit in ADDR_WIDTH");
  end

  typedef enum logic [1:0] {S_LOAD, S_LOADED, S_STREAM} state_e;

  state_e                    state_q;
  logic [ADDR_WIDTH-1:0]     wr_ptr_q, rd_ptr_q;
  logic                      all_issued_q;
  logic                      inflight_q, inflight_last_q;
  logic                      loaded_q, done_q;
  logic [1:0][IN_WIDTH-1:0]  ent_data_q [2];
  logic                      ent_last_q [2];
  logic                      head_q;
  logic [1:0]                buf_count_q, buf_count_d;
  logic [2:0]                occupancy;
  logic                      wr_fire, pop, issue, push_idx;

  assign load_ready_o = (state_q == S_LOAD);
  assign wr_fire      = load_valid_i & load_ready_o;
  assign out_valid_o  = (buf_count_q != 2'd0);
  assign out_data_o   = ent_data_q[head_q];
  assign out_last_o   = ent_last_q[head_q] & out_valid_o;
  assign pop          = out_valid_o & out_ready_i;
  assign loaded_o     = loaded_q;
  assign done_o       = done_q;

  // Slots already committed after this cycle's pop; at most two may be owed to the buffer.
  assign occupancy   = 3'(buf_count_q) + 3'(inflight_q) - 3'(pop);
  assign issue       = (state_q == S_STREAM) && !all_issued_q && (occupancy < 3'd2);
  assign buf_count_d = buf_count_q + 2'(inflight_q) - 2'(pop);
  assign push_idx    = head_q ^ buf_count_q[0];

  assign mem_we_o    = wr_fire;
  assign mem_re_o    = issue;
  assign mem_wdata_o = load_data_i;

  always_comb begin
    mem_addr0_o = '0;
    mem_addr1_o = '0;
    if (wr_fire) begin
      mem_addr0_o = wr_ptr_q;
      mem_addr1_o = wr_ptr_q + ADDR_ONE;
    end else if (issue) begin
      mem_addr0_o = rd_ptr_q;
      mem_addr1_o = rd_ptr_q + ADDR_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q         <= S_LOAD;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      all_issued_q    <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      loaded_q        <= 1'b0;
      done_q          <= 1'b0;
      head_q          <= 1'b0;
      buf_count_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        ent_data_q[i] <= '0;
        ent_last_q[i] <= 1'b0;
      end
    end else begin
      done_q          <= 1'b0;
      inflight_q      <= issue;
      inflight_last_q <= issue && (rd_ptr_q == LAST_ADDR);
      buf_count_q     <= buf_count_d;
      if (pop) head_q <= ~head_q;
      // Read data lands one cycle after the issue cycle; the last tag rides along.
      if (inflight_q) begin
        ent_data_q[push_idx] <= mem_rdata_i;
        ent_last_q[push_idx] <= inflight_last_q;
      end
      if (wr_fire) wr_ptr_q <= wr_ptr_q + ADDR_TWO;
      if (issue) begin
        rd_ptr_q <= rd_ptr_q + ADDR_TWO;
        if (rd_ptr_q == LAST_ADDR) all_issued_q <= 1'b1;
      end
      case (state_q)
        S_LOAD: begin
          if (wr_fire && (wr_ptr_q == LAST_ADDR)) begin
            state_q  <= S_LOADED;
            loaded_q <= 1'b1;
          end
        end
        S_LOADED: begin
          if (start_i) begin
            state_q      <= S_STREAM;
            rd_ptr_q     <= '0;
            all_issued_q <= 1'b0;
          end else if (reload_i) begin
            state_q  <= S_LOAD;
            wr_ptr_q <= '0;
            loaded_q <= 1'b0;
          end
        end
        S_STREAM: begin
          if (pop && out_last_o) begin
            state_q <= S_LOADED;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

`ifdef PROJ_CTRL_PERF_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_q <= '0;
    end else if ((state_q == S_LOADED) && start_i) begin
      stall_q <= '0;
    end else if ((state_q == S_STREAM) && out_valid_o && !out_ready_i && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count_o = stall_q;
`else
  assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_projection_mem_ctrl.sv
// Bench for projection_mem_ctrl: random load data, varied backpressure, reset/reload corner cases.
module tb_projection_mem_ctrl;

  localparam int NW = 250;
  localparam int NP = NW / 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_valid, load_ready;
  logic [1:0][15:0] load_data;
  logic             start, reload, loaded;
  logic             out_valid, out_ready, out_last, done;
  logic [1:0][15:0] out_data;
  logic [7:0]       mem_addr0, mem_addr1;
  logic             mem_we, mem_re;
  logic [1:0][15:0] mem_wdata, mem_rdata;
  logic [15:0]      stall_count;

  logic [15:0] mem [256];
  logic [15:0] ref_words [NW];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  projection_mem_ctrl dut (
    .clk_i(clk), .reset_i(reset),
    .load_valid_i(load_valid), .load_ready_o(load_ready), .load_data_i(load_data),
    .start_i(start), .reload_i(reload), .loaded_o(loaded),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_last_o(out_last), .done_o(done),
    .mem_addr0_o(mem_addr0), .mem_addr1_o(mem_addr1),
    .mem_we_o(mem_we), .mem_re_o(mem_re),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .stall_count_o(stall_count)
  );

  // Dual-port memory with registered read.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr0] <= mem_wdata[0];
      mem[mem_addr1] <= mem_wdata[1];
    end
    if (mem_re) begin
      mem_rdata[0] <= mem[mem_addr0];
      mem_rdata[1] <= mem[mem_addr1];
    end
  end

  task automatic test_reset();
    reset = 1'b1; load_valid = 0; load_data = '0; start = 0; reload = 0; out_ready = 0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL reset_loaded got %b exp 0", loaded); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", out_last); end
    checks++; if ({mem_we, mem_re} !== 2'b00) begin errors++; $display("FAIL reset_we_re got %b exp 00", {mem_we, mem_re}); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_count); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b exp 1", load_ready); end
    checks++; if (mem_addr0 !== 8'd0) begin errors++; $display("FAIL reset_addr_idle got %0d exp 0", mem_addr0); end
  endtask

  // gap_mode: 0 none (data i,i+1), 1 every 3rd cycle idle, 2 random idle; start_noise pulses start during LOAD.
  task automatic test_load(input int gap_mode, input bit start_noise);
    int acc = 0;
    int cyc = 0;
    bit v;
    logic [15:0] w0, w1;
    while (acc < NP && cyc < 2000) begin
      @(negedge clk);
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3) != 2;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      if (gap_mode == 0) begin w0 = 16'(2 * acc); w1 = 16'(2 * acc + 1); end
      else begin w0 = 16'($urandom); w1 = 16'($urandom); end
      load_valid = v; load_data[0] = w0; load_data[1] = w1;
      start = start_noise && (acc < NP - 5) && $urandom_range(0, 1) == 1;
      #1;
      checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL load_ready got %b exp 1 at pair %0d", load_ready, acc); end
      checks++; if (mem_we !== v) begin errors++; $display("FAIL load_we got %b exp %b at pair %0d", mem_we, v, acc); end
      checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL load_re got %b exp 0", mem_re); end
      if (v) begin
        checks++;
        if (mem_addr0 !== 8'(2 * acc) || mem_addr1 !== 8'(2 * acc + 1)) begin
          errors++; $display("FAIL load_addr got %0d/%0d exp %0d/%0d", mem_addr0, mem_addr1, 2 * acc, 2 * acc + 1);
        end
        ref_words[2 * acc] = w0; ref_words[2 * acc + 1] = w1;
        acc++;
      end
      cyc++;
    end
    checks++; if (acc != NP) begin errors++; $display("FAIL load_timeout got %0d pairs exp %0d", acc, NP); end
    @(negedge clk);
    load_valid = 0; start = 0;
    #1;
    checks++; if (loaded !== 1'b1) begin errors++; $display("FAIL load_loaded got %b exp 1", loaded); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load_ready_after got %b exp 0", load_ready); end
    checks++; if ({mem_we, mem_re, out_valid} !== 3'b000) begin errors++; $display("FAIL load_idle got %b exp 000", {mem_we, mem_re, out_valid}); end
  endtask

  // rmode: 0 always ready, 1 ready pattern 1,0,0,1, 2 random; abort_after>0 returns after that many beats.
  task automatic test_stream(input int rmode, input bit with_reload, input bit mid_noise, input int abort_after);
    int k = 0;
    int cyc = 0;
    int first = -1;
    int stalls = 0;
    bit finished = 0;
    @(negedge clk);
    start = 1'b1; reload = with_reload; out_ready = 1'b0;
    while (cyc < 2000 && !finished) begin
      @(negedge clk);
      start = 1'b0; reload = 1'b0;
      if (mid_noise && k >= 10 && k < 14) begin start = 1'b1; reload = $urandom_range(0, 1) == 1; end
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = $urandom_range(0, 1) == 1;
      endcase
      #1;
      checks++; if (done !== (k == NP)) begin errors++; $display("FAIL stream_done got %b exp %b at beat %0d", done, k == NP, k); end
      if (k == NP) begin
        finished = 1;
      end else begin
        checks++; if (loaded !== 1'b1 || load_ready !== 1'b0) begin errors++; $display("FAIL stream_flags got %b%b exp 10", loaded, load_ready); end
        if (out_valid === 1'b1) begin
          if (first < 0) first = cyc;
          checks++;
          if (out_data !== {ref_words[2 * k + 1], ref_words[2 * k]}) begin
            errors++; $display("FAIL stream_data got %h exp %h at beat %0d", out_data, {ref_words[2 * k + 1], ref_words[2 * k]}, k);
          end
          checks++; if (out_last !== (k == NP - 1)) begin errors++; $display("FAIL stream_last got %b exp %b at beat %0d", out_last, k == NP - 1, k); end
          if (out_ready) k++; else stalls++;
        end else if (first >= 0 && rmode == 0) begin
          checks++; errors++; $display("FAIL stream_bubble got valid 0 exp 1 at beat %0d", k);
        end
        if (abort_after > 0 && k == abort_after) return;
      end
      cyc++;
    end
    checks++; if (!finished) begin errors++; $display("FAIL stream_timeout got %0d beats exp %0d", k, NP); end
    checks++; if (first != 2) begin errors++; $display("FAIL stream_latency got %0d exp 2", first); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_valid_end got %b exp 0", out_valid); end
`ifdef PROJ_CTRL_PERF_EN
    checks++; if (stall_count !== 16'(stalls)) begin errors++; $display("FAIL stream_stalls got %0d exp %0d", stall_count, stalls); end
`else
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL stream_stalls got %0d exp 0", stall_count); end
`endif
    @(negedge clk); #1;
    checks++; if ({done, mem_re, out_valid} !== 3'b000) begin errors++; $display("FAIL stream_after got %b exp 000", {done, mem_re, out_valid}); end
    checks++; if ({loaded, load_ready} !== 2'b10) begin errors++; $display("FAIL stream_state got %b exp 10", {loaded, load_ready}); end
  endtask

  task automatic test_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    #1;
    checks++; if ({loaded, load_ready} !== 2'b01) begin errors++; $display("FAIL reload_flags got %b exp 01", {loaded, load_ready}); end
    checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL reload_re got %b exp 0", mem_re); end
  endtask

  task automatic test_reset_mid_stream();
    test_stream(2, 0, 0, 40);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b exp 0", out_valid); end
    checks++; if (loaded !== 1'b0) begin errors++; $display("FAIL midreset_loaded got %b exp 0", loaded); end
    checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL midreset_re got %b exp 0", mem_re); end
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b exp 1", load_ready); end
  endtask

  initial begin
    test_reset();
    test_load(0, 0);
    test_stream(0, 0, 0, 0);
    test_stream(1, 0, 0, 0);
    test_stream(2, 0, 1, 0);
    test_reload();
    test_load(1, 1);
    test_stream(0, 1, 0, 0);
    test_reset_mid_stream();
    test_load(2, 0);
    test_stream(1, 0, 0, 0);
    test_reload();
    test_load(0, 0);
    test_stream(2, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
